// File: rtl/sample_packetizer_pkg.sv
// sample_packetizer_pkg: shared state encoding, header default and checksum helper
package sample_packetizer_pkg;
  typedef enum logic [2:0] {IDLE, HDR, SEQ, REQ, WAIT, SEND, CSUM} packetStateT;
  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;
  function automatic logic [7:0] checksum(input logic [7:0] sum);
    return 8'h00 - sum;
  endfunction
endpackage

// File: rtl/sample_packetizer_tx.sv
// packet_tx_reg: single-entry output register; a loaded byte holds until the transmitter takes it
module packet_tx_reg (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Load,
  input  logic [7:0] LoadData,
  input  logic       TxReady,
  output logic       TxValid,
  output logic [7:0] TxData,
  output logic       Transfer
);
  assign Transfer = TxValid && TxReady;
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      TxValid <= 1'b0;
      TxData <= 8'h00;
    end else if (Load) begin
      TxValid <= 1'b1;
      TxData <= LoadData;
    end else if (Transfer) TxValid <= 1'b0;
endmodule

// File: rtl/sample_packetizer.sv
// sample_packetizer: reads a capture from DataStorage and frames it as header/seq/payload/checksum
module sample_packetizer
  import sample_packetizer_pkg::*;
#(
  parameter int         PAYLOAD_BYTES  = 16,
  parameter logic [7:0] HEADER_BYTE    = DEFAULT_HEADER,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       DataReadyToSend,
  output logic       ReadEnable,
  input  logic [7:0] DataIn,
  input  logic       DataValid,
  output logic [7:0] TxData,
  output logic       TxValid,
  input  logic       TxReady,
  output logic       Busy,
  output logic       Error,
  output logic [7:0] SeqNum
);
  packetStateT state, nextState;
  logic [7:0] byteCount, runSum, loadData;
  logic [9:0] timeoutCount;
  logic abortFlag, transfer, timeout, lastByte, txLoad;
  assign lastByte = byteCount == 8'(PAYLOAD_BYTES - 1);
  assign timeout = state == WAIT && !DataValid && timeoutCount == 10'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) state <= IDLE;
    else state <= nextState;
  always_comb begin
    nextState = state;
    case (state)
      IDLE: nextState = DataReadyToSend ? HDR : IDLE;
      HDR: nextState = transfer ? SEQ : HDR;
      SEQ: nextState = transfer ? REQ : SEQ;
      REQ: nextState = WAIT;
      WAIT: nextState = (DataValid || timeout) ? SEND : WAIT;
      SEND: nextState = !transfer ? SEND : lastByte ? CSUM : abortFlag ? SEND : REQ;
      CSUM: nextState = transfer ? IDLE : CSUM;
      default: nextState = IDLE;
    endcase
  end
  // The holding register is loaded on entry to each Tx state, so TxValid tracks those states
  always_comb begin
    ReadEnable = state == REQ;
    Busy = state != IDLE;
    txLoad = (state == IDLE && DataReadyToSend) || (state == HDR && transfer) ||
             (state == WAIT && (DataValid || timeout)) ||
             (state == SEND && transfer && (lastByte || abortFlag));
    loadData = state == IDLE ? HEADER_BYTE :
               state == HDR ? SeqNum :
               state == WAIT ? (DataValid ? DataIn : 8'h00) :
               lastByte ? checksum(runSum + TxData) : 8'h00;
  end
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      byteCount <= 8'h00;
      runSum <= 8'h00;
      timeoutCount <= 10'd0;
      abortFlag <= 1'b0;
      Error <= 1'b0;
      SeqNum <= 8'h00;
    end else begin
      if (state == IDLE) begin
        byteCount <= 8'h00;
        runSum <= 8'h00;
      end
      if (transfer && state != CSUM) runSum <= runSum + TxData;
      if (transfer && state == SEND && !lastByte) byteCount <= byteCount + 8'd1;
      timeoutCount <= state == WAIT ? timeoutCount + 10'd1 : 10'd0;
      if (timeout) begin
        Error <= 1'b1;
        abortFlag <= 1'b1;
      end
      if (transfer && state == CSUM) begin
        SeqNum <= SeqNum + 8'd1;
        abortFlag <= 1'b0;
      end
    end
  packet_tx_reg txReg (
    .Clock(Clock),
    .Reset(Reset),
    .Load(txLoad),
    .LoadData(loadData),
    .TxReady(TxReady),
    .TxValid(TxValid),
    .TxData(TxData),
    .Transfer(transfer)
  );
endmodule
